// File: rtl/perm_inverse.sv
// perm_inverse: restores a permuted frame to original slot order and flags malformed index maps
// Ports: clk/rst (async, active-high), clear (sync abort back to LOAD),
//   in_valid/in_ready/in_data/in_idx (permuted element plus its original slot),
//   out_valid/out_ready/out_data/out_idx/out_last (slots 0..SIZE-1 in order),
//   busy (frame loading or draining), error (bad index seen, held until clear/rst).
// Option PERM_INV_SRCPOS_EN adds out_src: arrival position of the element on out_data.
module perm_inverse #(
  parameter int SIZE   = 8,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
`ifdef PERM_INV_SRCPOS_EN
  output logic [IDX_W-1:0]  out_src,
`endif
  output logic              out_last,
  output logic              busy,
  output logic              error
);
  typedef enum logic [1:0] {LOAD, DRAIN, ERR} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem [SIZE];
  logic [SIZE-1:0] seen;
  logic [IDX_W-1:0] wr_cnt, rd_ptr;
  logic in_fire, out_fire, bad, full;
  assign in_ready  = state == LOAD;
  assign out_valid = state == DRAIN;
  assign error     = state == ERR;
  assign busy      = (in_ready && wr_cnt != '0) || out_valid;
  assign out_idx   = rd_ptr;
  assign out_last  = out_valid && rd_ptr == IDX_W'(SIZE - 1);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  // clear voids any handshake in the same cycle
  assign in_fire   = in_valid && in_ready && !clear;
  assign out_fire  = out_valid && out_ready && !clear;
  assign bad       = 32'(in_idx) >= SIZE || seen[in_idx];
  assign full      = wr_cnt == IDX_W'(SIZE - 1);
  always_comb begin
    state_n = state;
    state_n = clear ? LOAD :
              in_fire ? (bad ? ERR : full ? DRAIN : LOAD) :
              (out_fire && out_last) ? LOAD : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= LOAD;
      wr_cnt <= '0;
      rd_ptr <= '0;
      seen   <= '0;
    end else begin
      state <= state_n;
      if (clear) begin
        wr_cnt <= '0;
        rd_ptr <= '0;
        seen   <= '0;
      end else if (in_fire && !bad) begin
        seen[in_idx] <= 1'b1;
        wr_cnt       <= full ? '0 : wr_cnt + 1'b1;
      end else if (out_fire) begin
        rd_ptr <= out_last ? '0 : rd_ptr + 1'b1;
        if (out_last) seen <= '0;
      end
    end
  always_ff @(posedge clk)
    if (in_fire && !bad) mem[in_idx] <= in_data;
`ifdef PERM_INV_SRCPOS_EN
  logic [IDX_W-1:0] src [SIZE];
  always_ff @(posedge clk)
    if (in_fire && !bad) src[in_idx] <= wr_cnt;
  assign out_src = out_valid ? src[rd_ptr] : '0;
`endif
endmodule

// File: tb/tb_perm_inverse.sv
// tb_perm_inverse: randomized self-checking bench for perm_inverse against an array reference model
module tb_perm_inverse;
  localparam int SIZE = 8, DW = 32, IW = 3;
  logic clk = 0, rst = 1, clear = 0, in_valid = 0, out_ready = 0;
  logic [DW-1:0] in_data = '0;
  logic [IW-1:0] in_idx = '0;
  logic in_ready, out_valid, out_last, busy, error;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
`ifdef PERM_INV_SRCPOS_EN
  logic [IW-1:0] out_src;
`endif
  int n_checks = 0, n_fail = 0;
  logic [DW-1:0] d [SIZE];
  logic [IW-1:0] ix [SIZE];

  perm_inverse #(.SIZE(SIZE), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_idx(in_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
`ifdef PERM_INV_SRCPOS_EN
    .out_src(out_src),
`endif
    .out_last(out_last), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v, input logic [IW-1:0] i);
    int t = 0;
    in_valid = 1; in_data = v; in_idx = i;
    while (!in_ready && t < 20) begin tick; t++; end
    if (!in_ready) check("push_timeout", 0, 1);
    tick;
    in_valid = 0;
  endtask

  task automatic shuffle;
    for (int k = 0; k < SIZE; k++) begin ix[k] = IW'(k); d[k] = $urandom; end
    for (int k = SIZE - 1; k > 0; k--) begin
      int j = $urandom_range(0, k);
      logic [IW-1:0] tmp = ix[k];
      ix[k] = ix[j]; ix[j] = tmp;
    end
  endtask

  task automatic drain(input logic [DW-1:0] ed [SIZE], input logic [IW-1:0] es [SIZE], input int mode);
    int t = 0, ph = 0;
    while (!out_valid && t < 20) begin tick; t++; end
    check("drain_start", out_valid, 1);
    for (int s = 0; s < SIZE && ph < 200; ph++) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (ph % 3 == 0) : 1'($urandom_range(0, 1));
      check("out_valid", out_valid, 1);
      check("out_data", out_data, ed[s]);
      check("out_idx", out_idx, s);
      check("out_last", out_last, s == SIZE - 1);
      check("busy_drain", busy, 1);
      check("in_ready_drain", in_ready, 0);
`ifdef PERM_INV_SRCPOS_EN
      check("out_src", out_src, es[s]);
`else
      if (es[s] >= SIZE) check("src_range", es[s], 0);
`endif
      tick;
      if (out_ready) s++;
    end
    out_ready = 0;
    check("in_ready_back", in_ready, 1);
    check("out_valid_end", out_valid, 0);
    check("busy_end", busy, 0);
  endtask

  task automatic frame(input int mode);
    logic [DW-1:0] ed [SIZE];
    logic [IW-1:0] es [SIZE];
    for (int k = 0; k < SIZE; k++) begin ed[ix[k]] = d[k]; es[ix[k]] = IW'(k); end
    for (int k = 0; k < SIZE; k++) begin
      push(d[k], ix[k]);
      check("busy_load", busy, 1);
      if (k < SIZE - 1) begin
        check("no_early_out", out_valid, 0);
        repeat ($urandom_range(0, 1)) tick;
      end
    end
    check("latency", out_valid, 1);
    check("in_ready_full", in_ready, 0);
    drain(ed, es, mode);
  endtask

  initial begin
    repeat (3) tick;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
`ifdef PERM_INV_SRCPOS_EN
    check("rst_out_src", out_src, 0);
`endif
    rst = 0;
    tick;
    for (int k = 0; k < SIZE; k++) begin d[k] = DW'(SIZE - k); ix[k] = IW'(SIZE - 1 - k); end
    frame(0);
    for (int k = 0; k < SIZE; k++) begin d[k] = DW'(10 * k + 1); ix[k] = IW'((3 * k) % SIZE); end
    frame(0);
    repeat (3) begin shuffle; frame(2); end
    push(5, 0); push(6, 1); push(7, 2); push(9, 2);
    check("dup_error", error, 1);
    check("dup_in_ready", in_ready, 0);
    check("dup_out_valid", out_valid, 0);
    repeat (3) tick;
    check("err_sticky", error, 1);
    check("err_no_out", out_valid, 0);
    clear = 1; tick; clear = 0;
    check("clr_error", error, 0);
    check("clr_in_ready", in_ready, 1);
    check("clr_busy", busy, 0);
    shuffle; frame(0);
    shuffle; frame(1);
    shuffle;
    for (int k = 0; k < 5; k++) push($urandom, ix[k]);
    check("mid_busy", busy, 1);
    #2 rst = 1;
    #2;
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    rst = 0;
    tick;
    shuffle; frame(2);
    shuffle;
    for (int k = 0; k < SIZE - 1; k++) push(d[k], ix[k]);
    in_valid = 1; in_data = d[SIZE-1]; in_idx = ix[SIZE-1]; clear = 1;
    tick;
    in_valid = 0; clear = 0;
    check("clr_last_out_valid", out_valid, 0);
    check("clr_last_busy", busy, 0);
    check("clr_last_in_ready", in_ready, 1);
    repeat (2) tick;
    check("clr_last_no_drain", out_valid, 0);
    shuffle; frame(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
